// File: rtl/gmii_tx_arbiter.sv
// Two-port GMII transmit arbiter: round-robin grant, registered byte mux,
// inter-frame gap enforcement, start-timeout and max-frame-length policing.
module gmii_tx_arbiter #(
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 16,
    parameter int MAX_FRAME     = 1530
) (
    input  logic       gmii_tx_clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       tx_en0,
    input  logic       tx_en1,
    input  logic [7:0] txd0,
    input  logic [7:0] txd1,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_oversize
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        XMIT,
        IFG
    } state_t;

    state_t      state;
    logic        sel;
    logic        last;
    logic [15:0] tcnt;
    logic [10:0] fcnt;

    logic        sel_en;
    logic        sel_req;
    logic [7:0]  sel_txd;
    logic        pick;

    // Mux of the granted source and the round-robin choice for the next grant.
    always_comb begin
        sel_en  = sel ? tx_en1 : tx_en0;
        sel_req = sel ? req1 : req0;
        sel_txd = sel ? txd1 : txd0;
        pick    = (req0 && req1) ? ~last : req1;
    end

    // Arbitration FSM; every output is registered here.
    // fcnt holds the number of bytes already forwarded in the current frame,
    // so it starts at 1 when the first byte is accepted in GRANT.
    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sel          <= 1'b0;
            last         <= 1'b1;
            tcnt         <= '0;
            fcnt         <= '0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            gmii_tx_en   <= 1'b0;
            gmii_txd     <= 8'h00;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            err_timeout  <= 1'b0;
            err_oversize <= 1'b0;
            unique case (state)
                IDLE: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    tcnt       <= '0;
                    if (req0 || req1) begin
                        sel   <= pick;
                        gnt0  <= ~pick;
                        gnt1  <= pick;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (sel_en) begin
                        gmii_tx_en <= 1'b1;
                        gmii_txd   <= sel_txd;
                        fcnt       <= 11'd1;
                        state      <= XMIT;
                    end else if (!sel_req) begin
                        gmii_tx_en <= 1'b0;
                        gmii_txd   <= 8'h00;
                        gnt0       <= 1'b0;
                        gnt1       <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (tcnt == 16'(START_TIMEOUT - 1)) begin
                        gmii_tx_en  <= 1'b0;
                        gmii_txd    <= 8'h00;
                        gnt0        <= 1'b0;
                        gnt1        <= 1'b0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                        last        <= sel;
                        state       <= IDLE;
                    end else begin
                        gmii_tx_en <= 1'b0;
                        gmii_txd   <= sel_txd;
                        tcnt       <= tcnt + 16'd1;
                    end
                end
                XMIT: begin
                    if (!sel_en || fcnt == 11'(MAX_FRAME)) begin
                        gmii_tx_en   <= 1'b0;
                        gmii_txd     <= 8'h00;
                        gnt0         <= 1'b0;
                        gnt1         <= 1'b0;
                        err_oversize <= sel_en;
                        last         <= sel;
                        tcnt         <= '0;
                        state        <= IFG;
                    end else begin
                        gmii_tx_en <= 1'b1;
                        gmii_txd   <= sel_txd;
                        fcnt       <= fcnt + 11'd1;
                    end
                end
                IFG: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    if (tcnt == 16'(IFG_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter with a byte scoreboard
// and per-cycle output monitors.
module tb_gmii_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       tx_en0 = 1'b0, tx_en1 = 1'b0;
    logic [7:0] txd0 = 8'h00, txd1 = 8'h00;
    logic       gnt0, gnt1, gmii_tx_en, busy;
    logic       err_timeout, err_oversize;
    logic [7:0] gmii_txd;

    int cmp = 0;
    int mis = 0;
    logic [7:0] q[$];
    int en_run = 0, low_run = 0, frame_len = 0, last_gap = 0;
    int ovs_cnt = 0, to_cnt = 0;
    bit gnt1_seen = 0, prev_en = 0;

    always #5 clk = ~clk;

    gmii_tx_arbiter dut (
        .gmii_tx_clk (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .req1        (req1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .tx_en0      (tx_en0),
        .tx_en1      (tx_en1),
        .txd0        (txd0),
        .txd1        (txd1),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_oversize(err_oversize)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int port, input int i);
        if (port == 0) return 8'(i * 7 + 3);
        return 8'(8'hA5 ^ i);
    endfunction

    task automatic drive(input int port, input logic en, input logic [7:0] d);
        if (port == 0) begin
            tx_en0 = en;
            txd0   = d;
        end else begin
            tx_en1 = en;
            txd1   = d;
        end
    endtask

    task automatic set_req(input int port, input logic v);
        if (port == 0) req0 = v;
        else req1 = v;
    endtask

    task automatic wait_gnt(input int port);
        int k = 0;
        while (!(gnt0 || gnt1) && k < 200) begin
            tick();
            k++;
        end
        check("grant_port", {30'd0, gnt1, gnt0},
              (port == 0) ? 32'd1 : 32'd2);
    endtask

    task automatic send_frame(input int port, input int len, input int pre,
                              input bit eager, input bit keep_req);
        int k;
        set_req(port, 1'b1);
        if (eager) drive(port, 1'b1, pat(port, 0));
        wait_gnt(port);
        if (eager) begin
            q.push_back(pat(port, 0));
            for (int i = 1; i < len; i++) begin
                tick();
                drive(port, 1'b1, pat(port, i));
                q.push_back(pat(port, i));
            end
            tick();
        end else begin
            repeat (pre) tick();
            for (int i = 0; i < len; i++) begin
                drive(port, 1'b1, pat(port, i));
                q.push_back(pat(port, i));
                tick();
            end
        end
        drive(port, 1'b0, 8'h00);
        if (!keep_req) set_req(port, 1'b0);
        k = 0;
        while ((gnt0 || gnt1) && k < 50) begin
            tick();
            k++;
        end
        tick();
        check("gnt_released", {30'd0, gnt1, gnt0}, 0);
        check("frame_len", frame_len, len);
        check("sb_drained", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Output monitor: scoreboard pops, frame/gap lengths, pulse counts.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (gmii_tx_en) begin
            if (!prev_en) begin
                last_gap = low_run;
                en_run   = 0;
            end
            en_run++;
            if (q.size() == 0) begin
                check("sb_extra_byte", {24'd0, gmii_txd}, 32'h100);
            end else begin
                exp = q.pop_front();
                check("byte", {24'd0, gmii_txd}, {24'd0, exp});
            end
        end else begin
            if (prev_en) begin
                frame_len = en_run;
                low_run   = 0;
            end
            low_run++;
        end
        prev_en = gmii_tx_en;
        if (err_oversize) ovs_cnt++;
        if (err_timeout) to_cnt++;
        if (gnt1) gnt1_seen = 1;
        if (gnt0 || gnt1)
            check("gnt_onehot", {31'd0, gnt0 & gnt1}, 0);
        else
            check("ungranted_out_zero", {23'd0, gmii_tx_en, gmii_txd}, 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit dropped;

        #2;
        check("rst_outputs",
              {19'd0, gnt0, gnt1, gmii_tx_en, gmii_txd, busy,
               err_timeout, err_oversize}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // single source, frame starts two cycles after grant
        gnt1_seen = 0;
        send_frame(0, 60, 2, 0, 0);
        check("single_no_gnt1", {31'd0, gnt1_seen}, 0);

        // simultaneous requests after reset: port 0 then port 1
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        send_frame(0, 20, 0, 0, 0);
        send_frame(1, 20, 0, 1, 0);
        check("ifg_gap", last_gap, 14);

        // fairness with both requests held
        req0 = 1'b1;
        req1 = 1'b1;
        send_frame(0, 8, 0, 0, 1);
        send_frame(1, 8, 0, 0, 1);
        send_frame(0, 8, 1, 0, 1);
        send_frame(1, 8, 0, 0, 0);
        req0 = 1'b0;
        repeat (16) tick();

        // start timeout on port 1, then port 0 is served
        to_cnt = 0;
        req1 = 1'b1;
        wait_gnt(1);
        req0 = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!err_timeout && k < 40);
        check("timeout_latency", k, 16);
        check("timeout_gnt1_drop", {31'd0, gnt1}, 0);
        check("timeout_busy", {31'd0, busy}, 0);
        tick();
        check("timeout_pulse_width", {31'd0, err_timeout}, 0);
        check("gnt0_after_timeout", {31'd0, gnt0}, 1);
        req1 = 1'b0;
        send_frame(0, 10, 0, 0, 0);
        check("timeout_count", to_cnt, 1);
        repeat (16) tick();

        // oversize frame truncated at the maximum length
        ovs_cnt = 0;
        dropped = 0;
        req0 = 1'b1;
        wait_gnt(0);
        for (int i = 0; i < 1600; i++) begin
            drive(0, 1'b1, pat(0, i));
            if (i < 1530) q.push_back(pat(0, i));
            tick();
            if (!gnt0 && !dropped) begin
                dropped = 1;
                req0 = 1'b0;
                check("ovs_at_gnt_drop", {31'd0, err_oversize}, 1);
                check("ovs_busy_in_ifg", {31'd0, busy}, 1);
            end
        end
        drive(0, 1'b0, 8'h00);
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        check("ovs_frame_len", frame_len, 1530);
        check("ovs_pulse_count", ovs_cnt, 1);
        check("ovs_sb_drained", q.size(), 0);

        // reset asserted during byte 20 of a frame
        req0 = 1'b1;
        wait_gnt(0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1'b1, pat(0, i));
            q.push_back(pat(0, i));
            tick();
        end
        drive(0, 1'b1, pat(0, 20));
        check("pre_rst_tx_en", {31'd0, gmii_tx_en}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              {29'd0, gmii_tx_en, gnt0, busy}, 0);
        drive(0, 1'b0, 8'h00);
        req0 = 1'b0;
        tick();
        tick();
        q.delete();
        rst_n = 1'b1;
        tick();
        send_frame(0, 16, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
